trail_writer: RTL and testbench



---
 rtl/trail_writer.sv | 144 ++++++++++++++
 tb/tb_trail_writer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/trail_writer.sv
// trail_writer: fills the 640x480 frame buffer with background after reset or
// on request, and once per frame stamps each living bike's head position into
// the buffer as a two-pixel-wide trail word. One buffer word per clock.
module trail_writer #(
  parameter logic [3:0] BG_COLOR   = 4'h8,
  parameter logic [3:0] BLUE_COLOR = 4'h2,
  parameter logic [3:0] RED_COLOR  = 4'h4,
  parameter int         WORDS      = 153600
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        clear_req,
  input  logic [9:0]  Blue_X,
  input  logic [9:0]  Blue_Y,
  input  logic [9:0]  Red_X,
  input  logic [9:0]  Red_Y,
  input  logic        blue_alive,
  input  logic        red_alive,
  output logic        WE,
  output logic [18:0] write_address,
  output logic [15:0] Data_In,
  output logic        busy,
  output logic        clear_done
);

  typedef enum logic [1:0] {IDLE, CLEAR, WR_BLUE, WR_RED} state_t;

  localparam logic [18:0] LAST_ADDR = 19'(WORDS - 1);
  localparam logic [15:0] BG_WORD   = {4'h0, BG_COLOR, 4'h0, BG_COLOR};
  localparam logic [15:0] BLUE_WORD = {4'h0, BLUE_COLOR, 4'h0, BLUE_COLOR};
  localparam logic [15:0] RED_WORD  = {4'h0, RED_COLOR, 4'h0, RED_COLOR};

  state_t      state;
  logic        frame_prev;
  logic        clear_pending;
  logic [9:0]  red_x;
  logic [9:0]  red_y;
  logic        red_live;
  logic        frame_edge;

  // Y*320 + X/2 built from shifts so no multiplier is needed
  function automatic logic [18:0] pixel_addr(input logic [9:0] x, input logic [9:0] y);
    logic [18:0] y_ext;
    y_ext = {9'd0, y};
    return (y_ext << 8) + (y_ext << 6) + {10'd0, x[9:1]};
  endfunction

  function automatic logic on_screen(input logic [9:0] x, input logic [9:0] y);
    return (x < 10'd640) && (y < 10'd480);
  endfunction

  assign frame_edge = frame_clk & ~frame_prev;

  // Single state machine; outputs are registered alongside the state they belong to
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= CLEAR;
      WE            <= 1'b0;
      write_address <= '0;
      Data_In       <= '0;
      busy          <= 1'b0;
      clear_done    <= 1'b0;
      frame_prev    <= 1'b0;
      clear_pending <= 1'b0;
      red_x         <= '0;
      red_y         <= '0;
      red_live      <= 1'b0;
    end else begin
      frame_prev <= frame_clk;
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state         <= CLEAR;
            clear_pending <= 1'b0;
            WE            <= 1'b1;
            write_address <= '0;
            Data_In       <= BG_WORD;
            busy          <= 1'b1;
          end else if (frame_edge) begin
            state         <= WR_BLUE;
            red_x         <= Red_X;
            red_y         <= Red_Y;
            red_live      <= red_alive;
            WE            <= blue_alive && on_screen(Blue_X, Blue_Y);
            write_address <= pixel_addr(Blue_X, Blue_Y);
            Data_In       <= BLUE_WORD;
            busy          <= 1'b1;
          end else begin
            WE   <= 1'b0;
            busy <= 1'b0;
          end
        end
        CLEAR: begin
          if (!WE) begin
            // Straight out of reset the sweep has not begun yet
            WE            <= 1'b1;
            write_address <= '0;
            Data_In       <= BG_WORD;
            busy          <= 1'b1;
          end else if (write_address == LAST_ADDR) begin
            state      <= IDLE;
            WE         <= 1'b0;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            write_address <= write_address + 19'd1;
          end
        end
        WR_BLUE: begin
          if (clear_req) begin
            clear_pending <= 1'b1;
          end
          state         <= WR_RED;
          WE            <= red_live && on_screen(red_x, red_y);
          write_address <= pixel_addr(red_x, red_y);
          Data_In       <= RED_WORD;
          busy          <= 1'b1;
        end
        WR_RED: begin
          if (clear_pending || clear_req) begin
            state         <= CLEAR;
            clear_pending <= 1'b0;
            WE            <= 1'b1;
            write_address <= '0;
            Data_In       <= BG_WORD;
            busy          <= 1'b1;
          end else begin
            state <= IDLE;
            WE    <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          WE    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trail_writer.sv
// tb_trail_writer: directed and randomized frames checked against a simple
// arithmetic model of the buffer writes, plus full clear sweeps on a reduced
// buffer depth.
module tb_trail_writer;

  localparam int WORDS = 6000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic        clear_req;
  logic [9:0]  Blue_X;
  logic [9:0]  Blue_Y;
  logic [9:0]  Red_X;
  logic [9:0]  Red_Y;
  logic        blue_alive;
  logic        red_alive;
  logic        WE;
  logic [18:0] write_address;
  logic [15:0] Data_In;
  logic        busy;
  logic        clear_done;

  int checks = 0;
  int errors = 0;

  trail_writer #(.WORDS(WORDS)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .clear_req(clear_req),
    .Blue_X(Blue_X),
    .Blue_Y(Blue_Y),
    .Red_X(Red_X),
    .Red_Y(Red_Y),
    .blue_alive(blue_alive),
    .red_alive(red_alive),
    .WE(WE),
    .write_address(write_address),
    .Data_In(Data_In),
    .busy(busy),
    .clear_done(clear_done)
  );

  // 100 MHz clock
  always #5 Clk = ~Clk;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a bike writes when alive and on screen, at row*320 + column/2
  function automatic bit model_writes(input bit alive, input int x, input int y);
    return alive && (x < 640) && (y < 480);
  endfunction

  function automatic int model_addr(input int x, input int y);
    return y * 320 + x / 2;
  endfunction

  // Watch one complete sweep starting at its first write cycle; optionally poke
  // clear_req and a frame edge partway through, which must be ignored
  task automatic check_sweep(input string tag, input bit poke);
    int bad;
    bad = 0;
    for (int i = 0; i < WORDS; i++) begin
      if (!(WE === 1'b1 && write_address === 19'(i) && Data_In === 16'h0808 &&
            busy === 1'b1 && clear_done === 1'b0))
        bad++;
      if (poke && i == 100) begin
        clear_req = 1'b1;
        frame_clk = 1'b1;
      end else if (poke && i == 101) begin
        clear_req = 1'b0;
        frame_clk = 1'b0;
      end
      tick();
    end
    check_output({tag, "_bad_cycles"}, bad, 0);
    check_output({tag, "_done"}, clear_done, 1);
    check_output({tag, "_we_after"}, WE, 0);
    check_output({tag, "_busy_after"}, busy, 0);
    tick();
    check_output({tag, "_done_once"}, clear_done, 0);
  endtask

  // One frame edge; model predicts both write cycles and the return to IDLE
  task automatic apply_frame(input string tag, input int bx, input int by, input int rx,
                             input int ry, input bit ba, input bit ra, input bit clr_mid);
    Blue_X     = 10'(bx);
    Blue_Y     = 10'(by);
    Red_X      = 10'(rx);
    Red_Y      = 10'(ry);
    blue_alive = ba;
    red_alive  = ra;
    frame_clk  = 1'b1;
    tick();
    check_output({tag, "_blue_we"}, WE, model_writes(ba, bx, by));
    check_output({tag, "_blue_busy"}, busy, 1);
    if (model_writes(ba, bx, by)) begin
      check_output({tag, "_blue_addr"}, write_address, model_addr(bx, by));
      check_output({tag, "_blue_data"}, Data_In, 16'h0202);
    end
    Blue_X = 10'($urandom_range(0, 1023));
    Red_X  = 10'($urandom_range(0, 1023));
    red_alive = 1'($urandom_range(0, 1));
    if (clr_mid) clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check_output({tag, "_red_we"}, WE, model_writes(ra, rx, ry));
    check_output({tag, "_red_busy"}, busy, 1);
    if (model_writes(ra, rx, ry)) begin
      check_output({tag, "_red_addr"}, write_address, model_addr(rx, ry));
      check_output({tag, "_red_data"}, Data_In, 16'h0404);
    end
    tick();
    frame_clk = 1'b0;
    if (clr_mid) begin
      check_output({tag, "_clr_we"}, WE, 1);
      check_output({tag, "_clr_addr"}, write_address, 0);
      check_output({tag, "_clr_data"}, Data_In, 16'h0808);
    end else begin
      check_output({tag, "_idle_we"}, WE, 0);
      check_output({tag, "_idle_busy"}, busy, 0);
    end
  endtask

  // Directed scenarios followed by a batch of random frames
  initial begin : apply_stimulus
    int budget;
    Reset = 1'b1;
    frame_clk = 1'b0;
    clear_req = 1'b0;
    Blue_X = '0; Blue_Y = '0; Red_X = '0; Red_Y = '0;
    blue_alive = 1'b0; red_alive = 1'b0;
    tick(); tick(); tick();
    check_output("rst_we", WE, 0);
    check_output("rst_addr", write_address, 0);
    check_output("rst_data", Data_In, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", clear_done, 0);

    Reset = 1'b0;
    budget = 0;
    while (WE !== 1'b1 && budget < 4) begin
      tick();
      budget++;
    end
    check_output("sweep_start", WE, 1);
    check_sweep("init_sweep", 1'b1);

    tick();
    apply_frame("plan_a", 100, 50, 201, 479, 1'b1, 1'b1, 1'b0);
    tick();
    apply_frame("offscreen", 640, 10, 300, 300, 1'b1, 1'b0, 1'b0);
    tick();
    apply_frame("same_pos", 10, 10, 10, 10, 1'b1, 1'b1, 1'b0);
    tick();
    apply_frame("red_y_edge", 639, 479, 5, 480, 1'b1, 1'b1, 1'b0);
    tick();

    apply_frame("clr_mid", 20, 30, 40, 60, 1'b1, 1'b1, 1'b1);
    check_sweep("mid_sweep", 1'b0);

    frame_clk = 1'b1;
    clear_req = 1'b1;
    Blue_X = 10'd100; Blue_Y = 10'd100; blue_alive = 1'b1;
    tick();
    clear_req = 1'b0;
    check_output("clr_wins_we", WE, 1);
    check_output("clr_wins_addr", write_address, 0);
    check_output("clr_wins_data", Data_In, 16'h0808);
    check_sweep("clr_wins_sweep", 1'b0);
    frame_clk = 1'b0;
    tick();

    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    budget = 0;
    while (write_address !== 19'd5000 && budget < WORDS + 10) begin
      tick();
      budget++;
    end
    check_output("reach_5000", write_address, 5000);
    Reset = 1'b1;
    tick();
    check_output("mid_rst_we", WE, 0);
    check_output("mid_rst_addr", write_address, 0);
    check_output("mid_rst_data", Data_In, 0);
    check_output("mid_rst_busy", busy, 0);
    Reset = 1'b0;
    tick();
    check_output("restart_we", WE, 1);
    check_sweep("restart_sweep", 1'b0);

    for (int n = 0; n < 24; n++) begin
      tick();
      apply_frame("rand", int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                  int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
